// File: rtl/wm8731_pkg.sv
// ============================================================================
// Module   : wm8731_pkg
// Brief    : Shared I2C state encoding and audio framing constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wm8731_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        ADDR  = 4'd2,
        ACK0  = 4'd3,
        HI    = 4'd4,
        ACK1  = 4'd5,
        LO    = 4'd6,
        ACK2  = 4'd7,
        STOP  = 4'd8
    } i2c_state_t;

    localparam int         c_bclk_half       = 8;
    localparam int         c_half_frame_bits = 32;
    localparam int         c_sample_w        = 16;
    localparam logic [6:0] c_def_dev_addr    = 7'h1A;

endpackage

`default_nettype wire

// File: rtl/wm8731_if.sv
// ============================================================================
// Module   : wm8731_if
// Brief    : Control-word request and codec pin bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wm8731_if;
    logic        InitialiseTransfer;
    logic [15:0] message;
    logic        SCLK;
    logic        SDIN;
    logic        MCLK;
    logic        BCLK;
    logic        DACLRC;
    logic        DACDAT;

    // master: the driver; slave: the requester/codec side
    modport master (
        input  InitialiseTransfer, message,
        output SCLK, SDIN, MCLK, BCLK, DACLRC, DACDAT
    );
    modport slave (
        output InitialiseTransfer, message,
        input  SCLK, SDIN, MCLK, BCLK, DACLRC, DACDAT
    );
endinterface

`default_nettype wire

// File: rtl/wm8731_i2s_tx.sv
// ============================================================================
// Module   : wm8731_i2s_tx
// Brief    : Free-running MCLK/BCLK/DACLRC and I2S-format DACDAT generator.
//            AUDIO_SAWTOOTH_EN selects a per-frame sawtooth sample.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wm8731_i2s_tx
    import wm8731_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      o_mclk,
    output logic      o_bclk,
    output logic      o_daclrc,
    output logic      o_dacdat
);

    localparam int c_div_w = $clog2(2 * c_bclk_half);
    localparam int c_bit_w = $clog2(c_half_frame_bits);
    localparam int c_idx_w = $clog2(c_sample_w);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(2 * c_bclk_half - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_half_frame_bits - 1);

    logic [c_div_w-1:0]    r_div;
    logic [c_bit_w-1:0]    r_bit;
    logic                  r_lrc;
    logic                  r_dat;
    logic [c_sample_w-1:0] r_sample;

    logic                  w_bclk_fall;
    logic [c_bit_w-1:0]    w_bit_next;
    logic [c_idx_w-1:0]    w_idx;
    logic                  w_dat_next;
    logic [c_sample_w-1:0] w_sample_next;

    // Slot 0 of each half-frame is the one-BCLK I2S delay; slots 1..16 carry MSB..LSB
    always_comb begin
        w_bclk_fall = (r_div == c_div_last);
        w_bit_next  = (r_bit == c_bit_last) ? '0 : r_bit + 1'b1;
        w_idx       = c_idx_w'(c_sample_w - int'(w_bit_next));
        w_dat_next  = 1'b0;
        if (w_bit_next != '0 && w_bit_next <= c_bit_w'(c_sample_w)) begin
            w_dat_next = r_sample[w_idx];
        end
`ifdef AUDIO_SAWTOOTH_EN
        w_sample_next = r_sample + 16'h0100;
`else
        w_sample_next = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_bit    <= '0;
            r_lrc    <= 1'b0;
            r_dat    <= 1'b0;
            r_sample <= '0;
        end else begin
            r_div <= w_bclk_fall ? '0 : r_div + 1'b1;
            if (w_bclk_fall) begin
                r_bit <= w_bit_next;
                r_dat <= w_dat_next;
                if (r_bit == c_bit_last) begin
                    r_lrc <= ~r_lrc;
                    if (r_lrc) begin
                        r_sample <= w_sample_next;
                    end
                end
            end
        end
    end

    assign o_mclk   = r_div[1];
    assign o_bclk   = (r_div >= c_div_w'(c_bclk_half));
    assign o_daclrc = r_lrc;
    assign o_dacdat = r_dat;

endmodule

`default_nettype wire

// File: rtl/wm8731_driver.sv
// ============================================================================
// Module   : wm8731_driver
// Brief    : WM8731 codec driver: I2C control-word writer plus I2S audio port.
//            AUDIO_SAWTOOTH_EN enables the sawtooth test sample.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wm8731_driver
    import wm8731_pkg::*;
#(
    parameter int         I2C_QDIV = 32,
    parameter logic [6:0] DEV_ADDR = c_def_dev_addr
) (
    input  wire logic CLOCK50M,
    input  wire logic RESET,
    wm8731_if.master  bus
);

    localparam int               c_qw        = (I2C_QDIV > 1) ? $clog2(I2C_QDIV) : 1;
    localparam logic [c_qw-1:0]  c_qlast     = c_qw'(I2C_QDIV - 1);
    localparam logic [7:0]       c_addr_byte = {DEV_ADDR, 1'b0};

    i2c_state_t       r_state;
    i2c_state_t       w_state_next;
    logic [c_qw-1:0]  r_qcnt;
    logic [1:0]       r_quarter;
    logic [2:0]       r_bitcnt;
    logic             r_req_d;
    logic [15:0]      r_shift;
    logic [15:0]      r_pend_word;
    logic             r_pend;

    logic w_req_edge, w_qend, w_slot_end, w_byte_end, w_restart, w_data_state;
    logic w_bit, w_sclk, w_sdin;

    always_comb begin
        w_req_edge   = bus.InitialiseTransfer & ~r_req_d;
        w_qend       = (r_qcnt == c_qlast);
        w_slot_end   = w_qend && (r_quarter == 2'd3);
        w_byte_end   = w_slot_end && (r_bitcnt == 3'd7);
        w_restart    = (r_state == STOP) && w_slot_end && (r_pend || w_req_edge);
        w_data_state = (r_state == ADDR) || (r_state == HI) || (r_state == LO);
    end

    always_ff @(posedge CLOCK50M) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (w_req_edge) w_state_next = START;
            START: if (w_slot_end) w_state_next = ADDR;
            ADDR:  if (w_byte_end) w_state_next = ACK0;
            ACK0:  if (w_slot_end) w_state_next = HI;
            HI:    if (w_byte_end) w_state_next = ACK1;
            ACK1:  if (w_slot_end) w_state_next = LO;
            LO:    if (w_byte_end) w_state_next = ACK2;
            ACK2:  if (w_slot_end) w_state_next = STOP;
            STOP:  if (w_slot_end) w_state_next = w_restart ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bit slot: q0 data change with SCLK low, q1-q2 SCLK high, q3 SCLK low
    always_comb begin
        case (r_state)
            ADDR:    w_bit = c_addr_byte[~r_bitcnt];
            HI:      w_bit = r_shift[{1'b1, ~r_bitcnt}];
            LO:      w_bit = r_shift[{1'b0, ~r_bitcnt}];
            default: w_bit = 1'b1;
        endcase
        w_sclk = 1'b1;
        w_sdin = 1'b1;
        case (r_state)
            START: begin
                w_sclk = (r_quarter != 2'd3);
                w_sdin = (r_quarter == 2'd0);
            end
            ADDR, HI, LO: begin
                w_sclk = (r_quarter == 2'd1) || (r_quarter == 2'd2);
                w_sdin = w_bit;
            end
            ACK0, ACK1, ACK2: begin
                w_sclk = (r_quarter == 2'd1) || (r_quarter == 2'd2);
                w_sdin = 1'b1;
            end
            STOP: begin
                w_sclk = (r_quarter != 2'd0);
                w_sdin = r_quarter[1];
            end
            default: begin
                w_sclk = 1'b1;
                w_sdin = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK50M) begin
        if (!RESET) begin
            r_qcnt      <= '0;
            r_quarter   <= '0;
            r_bitcnt    <= '0;
            r_req_d     <= 1'b0;
            r_shift     <= '0;
            r_pend_word <= '0;
            r_pend      <= 1'b0;
        end else begin
            r_req_d <= bus.InitialiseTransfer;
            if (r_state == IDLE) begin
                r_qcnt    <= '0;
                r_quarter <= '0;
                r_bitcnt  <= '0;
            end else begin
                r_qcnt <= w_qend ? '0 : r_qcnt + 1'b1;
                if (w_qend) r_quarter <= r_quarter + 2'd1;
                if (w_slot_end) r_bitcnt <= w_data_state ? r_bitcnt + 3'd1 : 3'd0;
            end
            // A request arriving on the last STOP clock supersedes any pending word
            if (r_state == IDLE && w_req_edge) begin
                r_shift <= bus.message;
            end else if (w_restart) begin
                r_shift <= w_req_edge ? bus.message : r_pend_word;
                r_pend  <= 1'b0;
            end else if (w_req_edge) begin
                r_pend      <= 1'b1;
                r_pend_word <= bus.message;
            end
        end
    end

    assign bus.SCLK = w_sclk;
    assign bus.SDIN = w_sdin;

    wm8731_i2s_tx u_i2s_tx (
        .clk      (CLOCK50M),
        .rst_n    (RESET),
        .o_mclk   (bus.MCLK),
        .o_bclk   (bus.BCLK),
        .o_daclrc (bus.DACLRC),
        .o_dacdat (bus.DACDAT)
    );

endmodule

`default_nettype wire

// File: tb/tb_wm8731_driver.sv
// ============================================================================
// Module   : tb_wm8731_driver
// Brief    : Self-checking bench for wm8731_driver (I2C frames and I2S audio).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wm8731_driver;

    localparam int FRAME = 29 * 4 * 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wm8731_if bus ();

    wm8731_driver #(.I2C_QDIV(32), .DEV_ADDR(7'h1A)) dut (
        .CLOCK50M (clk),
        .RESET    (rst_n),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_busy, m_pend, m_prev;
    int          m_s, m_ta, cyc;
    logic [15:0] m_word, m_pend_word;

    // Pin decoders
    logic [26:0] frames[$];
    int          fbits[$];
    logic [15:0] words[$];
    logic [27:0] d_bits;
    int          d_nbits;
    bit          d_active;
    logic        p_sclk, p_sdin, p_mclk, p_bclk, p_lrc, a_lrc_last;
    int          a_pos;
    logic [15:0] a_word;
    int          mclk_last = -1, bclk_last = -1, lrc_last = -1;
    int          mclk_per = -1, bclk_per = -1, lrc_half = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {SCLK, SDIN} for a frame carrying word w, s clocks after it started
    function automatic logic [1:0] i2c_expect(bit busy, int s, logic [15:0] w);
        int slot, q, i, pos;
        logic [7:0] b;
        if (!busy) return 2'b11;
        slot = s / 128;
        q    = (s % 128) / 32;
        if (slot == 0)  return {q != 3, q == 0};
        if (slot == 28) return {q != 0, q >= 2};
        i   = slot - 1;
        pos = i % 9;
        case (i / 9)
            0:       b = 8'h34;
            1:       b = w[15:8];
            default: b = w[7:0];
        endcase
        if (pos == 8) return {(q == 1 || q == 2), 1'b1};
        return {(q == 1 || q == 2), b[7-pos]};
    endfunction

    // {MCLK, BCLK, DACLRC, DACDAT} t clocks after reset release
    function automatic logic [3:0] aud_expect(int t);
        int k, f;
        logic [15:0] smp;
        logic dat;
        k = (t / 16) % 32;
        f = t / 1024;
`ifdef AUDIO_SAWTOOTH_EN
        smp = 16'(f * 256);
`else
        smp = 16'h0000;
`endif
        dat = (k >= 1 && k <= 16) ? smp[16-k] : 1'b0;
        return {((t / 2) % 2) == 1, ((t / 8) % 2) == 1, ((t / 512) % 2) == 1, dat};
    endfunction

    initial begin
        logic req_edge;
        m_busy = 0; m_pend = 0; m_prev = 0; m_s = 0; m_ta = 0; cyc = 0;
        m_word = '0; m_pend_word = '0;
        d_bits = '0; d_nbits = 0; d_active = 0; a_pos = -1; a_word = '0; a_lrc_last = 0;
        p_sclk = 1; p_sdin = 1; p_mclk = 0; p_bclk = 0; p_lrc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_busy = 0; m_pend = 0; m_prev = 0; m_ta = 0;
            end else begin
                req_edge = bus.InitialiseTransfer && !m_prev;
                m_prev   = bus.InitialiseTransfer;
                m_ta++;
                if (m_busy) begin
                    m_s++;
                    if (m_s == FRAME) m_busy = 0;
                end
                if (!m_busy) begin
                    if (req_edge) begin
                        m_busy = 1; m_s = 0; m_word = bus.message; m_pend = 0;
                    end else if (m_pend) begin
                        m_busy = 1; m_s = 0; m_word = m_pend_word; m_pend = 0;
                    end
                end else if (req_edge) begin
                    m_pend = 1; m_pend_word = bus.message;
                end
            end
            @(negedge clk);
            chk("i2c_pins", 32'({bus.SCLK, bus.SDIN}), 32'(i2c_expect(m_busy, m_s, m_word)));
            chk("audio_pins", 32'({bus.MCLK, bus.BCLK, bus.DACLRC, bus.DACDAT}), 32'(aud_expect(m_ta)));
            if (!rst_n) begin
                d_active = 0; d_nbits = 0; a_pos = -1; a_lrc_last = 0;
            end else begin
                if (p_sclk && bus.SCLK && p_sdin && !bus.SDIN) begin
                    d_active = 1; d_nbits = 0; d_bits = '0;
                end else if (p_sclk && bus.SCLK && !p_sdin && bus.SDIN && d_active) begin
                    frames.push_back(d_bits[27:1]);
                    fbits.push_back(d_nbits - 1);
                    d_active = 0;
                end else if (!p_sclk && bus.SCLK && d_active) begin
                    d_bits = {d_bits[26:0], bus.SDIN};
                    d_nbits++;
                end
                if (!p_bclk && bus.BCLK) begin
                    if (bus.DACLRC != a_lrc_last) begin
                        a_pos = 0; a_lrc_last = bus.DACLRC;
                    end else begin
                        a_pos++;
                    end
                    if (a_pos >= 1 && a_pos <= 16) a_word = {a_word[14:0], bus.DACDAT};
                    if (a_pos == 16 && words.size() < 6) words.push_back(a_word);
                    if (bclk_last >= 0 && bclk_per < 0) bclk_per = cyc - bclk_last;
                    bclk_last = cyc;
                end
                if (!p_mclk && bus.MCLK) begin
                    if (mclk_last >= 0 && mclk_per < 0) mclk_per = cyc - mclk_last;
                    mclk_last = cyc;
                end
                if (p_lrc != bus.DACLRC) begin
                    if (lrc_last >= 0 && lrc_half < 0) lrc_half = cyc - lrc_last;
                    lrc_last = cyc;
                end
            end
            p_sclk = bus.SCLK; p_sdin = bus.SDIN; p_mclk = bus.MCLK;
            p_bclk = bus.BCLK; p_lrc = bus.DACLRC;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [15:0] msg, input int n);
        bus.message = msg;
        bus.InitialiseTransfer = 1'b1;
        tick(n);
        bus.InitialiseTransfer = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        checks++;
        if (frames.size() < n) begin
            failures++;
            $display("FAIL wait_frames: got %0d frames expected %0d within %0d cycles", frames.size(), n, budget);
        end
    endtask

    task automatic chk_frame(input int idx, input logic [7:0] b1, input logic [7:0] b2);
        logic [26:0] f;
        if (idx >= frames.size()) begin
            checks++;
            failures++;
            $display("FAIL frame_missing: frame %0d absent, got %0d frames", idx, frames.size());
            return;
        end
        f = frames[idx];
        chk("addr_byte", 32'(f[26:19]), 32'h34);
        chk("hi_byte", 32'(f[17:10]), 32'(b1));
        chk("lo_byte", 32'(f[8:1]), 32'(b2));
        chk("ack_slots", 32'({f[18], f[9], f[0]}), 32'h7);
        chk("frame_bits", 32'(fbits[idx]), 32'd27);
    endtask

    initial begin
        logic [15:0] exp_words[6];
`ifdef AUDIO_SAWTOOTH_EN
        exp_words = '{16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0200, 16'h0200};
`else
        exp_words = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
        bus.InitialiseTransfer = 1'b0;
        bus.message = 16'h0000;
        rst_n = 1'b0;
        tick(3);
        @(negedge clk);
        chk("reset_pins", 32'({bus.SCLK, bus.SDIN, bus.MCLK, bus.BCLK, bus.DACLRC, bus.DACDAT}), 32'b110000);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Single write with a long request pulse
        tick(5);
        pulse(16'hFAFA, 250);
        wait_frames(1, 5000);
        tick(200);
        chk("frames_single", 32'(frames.size()), 32'd1);
        chk_frame(0, 8'hFA, 8'hFA);
        chk("sclk_idle", 32'({bus.SCLK, bus.SDIN}), 32'b11);
        chk("mclk_period", 32'(mclk_per), 32'd4);
        chk("bclk_period", 32'(bclk_per), 32'd16);
        chk("daclrc_half", 32'(lrc_half), 32'd512);
        chk("audio_words", 32'(words.size()), 32'd6);
        for (int i = 0; i < words.size() && i < 6; i++) chk("audio_word", 32'(words[i]), 32'(exp_words[i]));

        // Queued request while busy
        pulse(16'hC3A5, 3);
        tick(1000);
        pulse(16'h8F8F, 5);
        wait_frames(3, 9000);
        tick(4000);
        chk("frames_queued", 32'(frames.size()), 32'd3);
        chk_frame(1, 8'hC3, 8'hA5);
        chk_frame(2, 8'h8F, 8'h8F);

        // Reset during HI byte with a pending request
        pulse(16'h1357, 2);
        tick(1600);
        pulse(16'h2468, 2);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_pins", 32'({bus.SCLK, bus.SDIN}), 32'b11);
        @(posedge clk); #2;
        rst_n = 1'b1;
        tick(5000);
        chk("frames_after_reset", 32'(frames.size()), 32'd3);
        pulse(16'h55AA, 2);
        wait_frames(4, 5000);
        chk_frame(3, 8'h55, 8'hAA);

        // Request level held high
        tick(200);
        pulse(16'h0C0C, 10000);
        tick(200);
        chk("frames_held", 32'(frames.size()), 32'd5);
        chk_frame(4, 8'h0C, 8'h0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
